// File: rtl/seq_bidir_shifter.sv
// Sequential bidirectional rotator: one bit position per clock behind valid/ready ports.
// Optional macro SEQ_SHIFT_MODE_EN adds in_mode (rotate / logical / arithmetic shift).
module seq_bidir_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_dir,
`ifdef SEQ_SHIFT_MODE_EN
    input  logic [1:0]       in_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_LOGIC = 2'b01;
    localparam logic [1:0] MODE_ARITH = 2'b10;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_eff;

    // Single-position move; the bit entering the vacated end depends on the mode.
    function automatic logic [WIDTH-1:0] step1(
        input logic [WIDTH-1:0] w,
        input logic             dir,
        input logic [1:0]       mode
    );
        logic lsb_in;
        logic msb_in;
        lsb_in = w[WIDTH-1];
        msb_in = w[0];
        if (mode == MODE_LOGIC) begin
            lsb_in = 1'b0;
            msb_in = 1'b0;
        end else if (mode == MODE_ARITH) begin
            lsb_in = 1'b0;
            msb_in = w[WIDTH-1];
        end
        if (dir)
            step1 = {msb_in, w[WIDTH-1:1]};
        else
            step1 = {w[WIDTH-2:0], lsb_in};
    endfunction

`ifdef SEQ_SHIFT_MODE_EN
    logic [1:0] mode_q, mode_d;

    always_ff @(posedge clk) begin
        if (!rst_n)
            mode_q <= 2'b00;
        else
            mode_q <= mode_d;
    end

    always_comb begin
        mode_d = mode_q;
        if (state_q == S_IDLE && in_valid)
            mode_d = in_mode;
    end

    assign mode_eff = mode_q;
`else
    assign mode_eff = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work_q  <= '0;
            count_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            work_q  <= work_d;
            count_q <= count_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid)
                    state_d = (in_shamt == '0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                if (count_q == SHW'(1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Inputs are only sampled in IDLE, so anything driven during SHIFT/DONE is ignored.
    always_comb begin
        work_d  = work_q;
        count_d = count_q;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    count_d = in_shamt;
                    dir_d   = in_dir;
                end
            end
            S_SHIFT: begin
                work_d  = step1(work_q, dir_q, mode_eff);
                count_d = count_q - SHW'(1);
            end
            default: begin
                work_d  = work_q;
                count_d = count_q;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        out_data  = work_q;
    end

endmodule

// File: tb/tb_seq_bidir_shifter.sv
// Randomized and directed bench for seq_bidir_shifter against a latency/result model.
module tb_seq_bidir_shifter;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_shamt;
    logic       in_dir;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int errors = 0;
    int checks = 0;

    seq_bidir_shifter #(.WIDTH(8), .SHW(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_shamt (in_shamt),
        .in_dir   (in_dir),
`ifdef SEQ_SHIFT_MODE_EN
        .in_mode  (in_mode),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-operation result from plain shift arithmetic.
    function automatic logic [7:0] model_op(input logic [7:0] d, input int n,
                                            input logic dir, input logic [1:0] mode);
        logic [15:0]       dd;
        logic [15:0]       t;
        logic signed [7:0] sd;
        logic [7:0]        r;
        dd = {d, d};
        sd = d;
        case (mode)
            2'b01:   r = dir ? (d >> n) : (d << n);
            2'b10:   r = dir ? 8'(sd >>> n) : (d << n);
            default: begin
                if (dir) begin
                    t = dd >> n;
                    r = t[7:0];
                end else begin
                    t = dd << n;
                    r = t[15:8];
                end
            end
        endcase
        return r;
    endfunction

    // Model: 0 idle, 1 waiting out the latency, 2 result presented.
    int         m_phase = 0;
    int         m_left  = 0;
    bit         m_ok    = 0;
    logic [7:0] m_res   = 8'h00;
    logic [7:0] m_last  = 8'h00;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ok    = 1;
            m_phase = 0;
            m_left  = 0;
            m_last  = 8'h00;
        end else if (m_ok) begin
            case (m_phase)
                0: if (in_valid) begin
                    m_res  = model_op(in_data, int'(in_shamt), in_dir, in_mode);
                    m_left = int'(in_shamt);
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_last  = m_res;
                    end else begin
                        m_phase = 1;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_last  = m_res;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_ok && rst_n) begin
            chk("m_in_ready", {31'b0, in_ready}, {31'b0, m_phase == 0});
            chk("m_busy", {31'b0, busy}, {31'b0, m_phase != 0});
            chk("m_out_valid", {31'b0, out_valid}, {31'b0, m_phase == 2});
            if (m_phase != 1)
                chk("m_out_data", {24'b0, out_data}, {24'b0, m_last});
        end
    end

    task automatic send(input logic [7:0] d, input logic [2:0] n, input logic dr,
                        input logic [1:0] md);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("req_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = n;
        in_dir   = dr;
`ifdef SEQ_SHIFT_MODE_EN
        in_mode  = md;
`else
        in_mode  = (md == 2'b00) ? 2'b00 : 2'b00;
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_shamt = 3'($urandom);
        in_dir   = 1'($urandom);
    endtask

    // Counts edges from the accept edge (inclusive) until out_valid is seen.
    task automatic wait_valid(output int edges);
        edges = 1;
        @(negedge clk);
        while (!out_valid && edges < 50) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic directed(input string name, input logic [7:0] d, input logic [2:0] n,
                            input logic dr, input logic [1:0] md, input logic [7:0] exp,
                            input int exp_edges);
        int e;
        send(d, n, dr, md);
        wait_valid(e);
        chk({name, "_lat"}, e, exp_edges);
        chk({name, "_data"}, {24'b0, out_data}, {24'b0, exp});
        consume();
    endtask

    initial begin
        int e;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = 8'h00; in_shamt = 3'd0; in_dir = 1'b0; in_mode = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {24'b0, out_data}, 32'h00);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;

        directed("rotl3", 8'h96, 3'd3, 1'b0, 2'b00, 8'hB4, 4);
        directed("rotr5", 8'h96, 3'd5, 1'b1, 2'b00, 8'hB4, 6);
        directed("rotr1", 8'h81, 3'd1, 1'b1, 2'b00, 8'hC0, 2);

        send(8'hA5, 3'd0, 1'b0, 2'b00);
        wait_valid(e);
        chk("zero_lat", e, 1);
        chk("zero_data", {24'b0, out_data}, 32'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_data", {24'b0, out_data}, 32'hA5);
        end
        consume();
        @(negedge clk);
        chk("post_hs_ready", {31'b0, in_ready}, 32'd1);
        chk("post_hs_valid", {31'b0, out_valid}, 32'd0);
        chk("idle_hold_data", {24'b0, out_data}, 32'hA5);
        @(posedge clk);
        #1;

        send(8'h96, 3'd7, 1'b0, 2'b00);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_data", {24'b0, out_data}, 32'h00);
        chk("abort_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        directed("after_abort", 8'h01, 3'd1, 1'b0, 2'b00, 8'h02, 2);

`ifdef SEQ_SHIFT_MODE_EN
        directed("asr2", 8'h96, 3'd2, 1'b1, 2'b10, 8'hE5, 3);
        directed("lsr2", 8'h96, 3'd2, 1'b1, 2'b01, 8'h25, 3);
        directed("lsl3", 8'h96, 3'd3, 1'b0, 2'b01, 8'hB0, 4);
        directed("asl3", 8'h96, 3'd3, 1'b0, 2'b10, 8'hB0, 4);
        directed("mode11", 8'h96, 3'd3, 1'b0, 2'b11, 8'hB4, 4);
`endif

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst_n     = ($urandom_range(0, 63) != 0);
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            in_shamt  = 3'($urandom);
            in_dir    = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
`ifdef SEQ_SHIFT_MODE_EN
            in_mode   = 2'($urandom);
`endif
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("final_idle", {31'b0, in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
